// File: rtl/gearbox_param.sv
// Width-conversion gearbox: IN_W-bit words in, OUT_W-bit words out, LSB-first.
// Carries per-bit error tags and supports a zero-padded flush of the final partial word.
module gearbox_param #(
   parameter int IN_W  = 256,
   parameter int OUT_W = 192,
   parameter int BUF_W = 448,
   parameter int LVL_W = 9
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_enable,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_datavalid,
   input  logic             in_dataerror,
   output logic             out_idle,
   output logic [OUT_W-1:0] out_data,
   output logic             out_datavalid,
   output logic             out_dataerror,
   output logic             out_partial,
   input  logic             in_idle,
   input  logic             in_flush,
   output logic             out_flushdone,
   output logic [LVL_W-1:0] out_level
);

   localparam logic [LVL_W-1:0] OUT_C = LVL_W'(OUT_W);
   localparam logic [LVL_W-1:0] IN_C  = LVL_W'(IN_W);
   localparam logic [LVL_W:0]   IN_L  = (LVL_W+1)'(IN_W);
   localparam logic [LVL_W:0]   BUF_L = (LVL_W+1)'(BUF_W);

   typedef enum logic {RUN, FLUSH} state_t;

   state_t           state_p0;
   logic [BUF_W-1:0] data_p0;
   logic [BUF_W-1:0] tag_p0;
   logic [LVL_W-1:0] cnt_p0;
   logic             flushdone_p0;

   logic [BUF_W-1:0] data_sh, tag_sh, data_n, tag_n;
   logic [BUF_W-1:0] ins_mask, ins_data, ins_tag;
   logic [LVL_W-1:0] take, rem, cnt_n;
   logic [OUT_W-1:0] out_mask;
   logic             pop, push, drained;

   function automatic logic [LVL_W-1:0] clamp_take(input logic [LVL_W-1:0] c);
      return (c >= OUT_C) ? OUT_C : c;
   endfunction

   always_comb begin
      take = clamp_take(cnt_p0);
      if (state_p0 == RUN)
         pop = in_enable & in_idle & (cnt_p0 >= OUT_C);
      else
         pop = in_enable & in_idle & (cnt_p0 != '0);
      rem      = pop ? (cnt_p0 - take) : cnt_p0;
      out_idle = in_enable & (state_p0 == RUN) & (({1'b0, rem} + IN_L) <= BUF_L);
      push     = out_idle & in_datavalid;

      // Only bits below the fill count are real; everything above is stale.
      out_mask      = (cnt_p0 >= OUT_C) ? {OUT_W{1'b1}} : ~({OUT_W{1'b1}} << cnt_p0);
      out_data      = data_p0[OUT_W-1:0] & out_mask;
      out_dataerror = |(tag_p0[OUT_W-1:0] & out_mask);
      out_datavalid = pop;
      out_partial   = pop & (cnt_p0 < OUT_C);

      data_sh  = pop ? (data_p0 >> take) : data_p0;
      tag_sh   = pop ? (tag_p0 >> take) : tag_p0;
      ins_mask = {{(BUF_W-IN_W){1'b0}}, {IN_W{1'b1}}} << rem;
      ins_data = {{(BUF_W-IN_W){1'b0}}, in_data} << rem;
      ins_tag  = {{(BUF_W-IN_W){1'b0}}, {IN_W{in_dataerror}}} << rem;
      data_n   = push ? ((data_sh & ~ins_mask) | ins_data) : data_sh;
      tag_n    = push ? ((tag_sh & ~ins_mask) | ins_tag) : tag_sh;
      cnt_n    = push ? (rem + IN_C) : rem;
      drained  = (cnt_n == '0);
   end

   // Single state stage: buffer, tags, fill count and flush FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_p0      <= '0;
         tag_p0       <= '0;
         cnt_p0       <= '0;
         state_p0     <= RUN;
         flushdone_p0 <= 1'b0;
      end else begin
         data_p0      <= data_n;
         tag_p0       <= tag_n;
         cnt_p0       <= cnt_n;
         flushdone_p0 <= 1'b0;
         if (in_enable) begin
            case (state_p0)
               RUN: begin
                  if (in_flush) begin
                     if (drained) flushdone_p0 <= 1'b1;
                     else         state_p0     <= FLUSH;
                  end
               end
               FLUSH: begin
                  if (drained) begin
                     state_p0     <= RUN;
                     flushdone_p0 <= 1'b1;
                  end
               end
               default: state_p0 <= RUN;
            endcase
         end
      end
   end

   assign out_flushdone = flushdone_p0;
   assign out_level     = cnt_p0;

   cnt_never_over: assert property (@(posedge clk) disable iff (!reset_n)
      ({1'b0, cnt_p0} <= BUF_L));

endmodule

// File: tb/tb_gearbox_param.sv
// Bench for gearbox_param: hand-derived vector table plus randomized traffic
// checked against a bit-queue reference model, on default and 64->48 configurations.
module tb_gearbox_param;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         en, dv, err, ii, fl;
   logic [255:0] din;

   logic         a_idle, a_vld, a_err, a_part, a_done;
   logic [191:0] a_data;
   logic [8:0]   a_lvl;
   logic         b_idle, b_vld, b_err, b_part, b_done;
   logic [47:0]  b_data;
   logic [6:0]   b_lvl;

   logic         sel;
   logic [255:0] d_data;
   logic [31:0]  d_lvl;
   logic         d_idle, d_vld, d_err, d_part, d_done;

   int n_cmp = 0;
   int n_fail = 0;

   bit dq[$];
   bit tq[$];
   bit mflush, mdone;
   int iw, ow, bw;

   typedef struct {
      logic en, dv, er, ii, fl;
      logic [255:0] din;
      logic e_vld, e_idle, e_part, e_done, e_err, e_cd;
      int e_lvl;
      logic [191:0] e_data;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;

   gearbox_param #(.IN_W(256), .OUT_W(192), .BUF_W(448), .LVL_W(9)) u_a (
      .clk(clk), .reset_n(reset_n), .in_enable(en), .in_data(din),
      .in_datavalid(dv), .in_dataerror(err), .out_idle(a_idle), .out_data(a_data),
      .out_datavalid(a_vld), .out_dataerror(a_err), .out_partial(a_part),
      .in_idle(ii), .in_flush(fl), .out_flushdone(a_done), .out_level(a_lvl));

   gearbox_param #(.IN_W(64), .OUT_W(48), .BUF_W(111), .LVL_W(7)) u_b (
      .clk(clk), .reset_n(reset_n), .in_enable(en), .in_data(din[63:0]),
      .in_datavalid(dv), .in_dataerror(err), .out_idle(b_idle), .out_data(b_data),
      .out_datavalid(b_vld), .out_dataerror(b_err), .out_partial(b_part),
      .in_idle(ii), .in_flush(fl), .out_flushdone(b_done), .out_level(b_lvl));

   always_comb begin
      if (sel) begin
         d_data = {208'b0, b_data}; d_lvl = {25'b0, b_lvl};
         d_idle = b_idle; d_vld = b_vld; d_err = b_err; d_part = b_part; d_done = b_done;
      end else begin
         d_data = {64'b0, a_data}; d_lvl = {23'b0, a_lvl};
         d_idle = a_idle; d_vld = a_vld; d_err = a_err; d_part = a_part; d_done = a_done;
      end
   end

   function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   // Reference model: the buffer is a queue of bits, oldest first.
   task automatic model_cycle();
      int cnt, take, rem;
      bit epop, eidle, epush, eerr, ndone;
      logic [255:0] ed;
      if (!reset_n) begin
         chk("rst_data", d_data, '0);
         chk("rst_vld", {255'b0, d_vld}, '0);
         chk("rst_idle", {255'b0, d_idle}, '0);
         chk("rst_err", {255'b0, d_err}, '0);
         chk("rst_part", {255'b0, d_part}, '0);
         chk("rst_done", {255'b0, d_done}, '0);
         chk("rst_lvl", {224'b0, d_lvl}, '0);
         dq.delete(); tq.delete(); mflush = 0; mdone = 0;
         return;
      end
      cnt   = dq.size();
      take  = (cnt < ow) ? cnt : ow;
      epop  = en && ii && (mflush ? (cnt > 0) : (cnt >= ow));
      rem   = epop ? cnt - take : cnt;
      eidle = en && !mflush && (rem + iw <= bw);
      epush = eidle && dv;
      ed = '0; eerr = 0;
      for (int i = 0; i < take; i++) begin
         ed[i] = dq[i];
         eerr |= tq[i];
      end
      chk("m_vld", {255'b0, d_vld}, {255'b0, epop});
      chk("m_idle", {255'b0, d_idle}, {255'b0, eidle});
      chk("m_lvl", {224'b0, d_lvl}, 256'(cnt));
      chk("m_done", {255'b0, d_done}, {255'b0, mdone});
      chk("m_part", {255'b0, d_part}, {255'b0, epop && (cnt < ow)});
      if (epop) begin
         chk("m_data", d_data, ed);
         chk("m_err", {255'b0, d_err}, {255'b0, eerr});
         for (int i = 0; i < take; i++) begin
            void'(dq.pop_front());
            void'(tq.pop_front());
         end
      end
      if (epush) begin
         for (int i = 0; i < iw; i++) begin
            dq.push_back(din[i]);
            tq.push_back(err);
         end
      end
      ndone = 0;
      if (en) begin
         if (!mflush && fl) begin
            if (dq.size() == 0) ndone = 1;
            else mflush = 1;
         end else if (mflush && dq.size() == 0) begin
            mflush = 0;
            ndone  = 1;
         end
      end
      mdone = ndone;
   endtask

   task automatic at_neg();
      @(negedge clk);
      model_cycle();
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      at_neg();
      to_next();
   endtask

   task automatic set_in(logic en_, logic dv_, logic er_, logic ii_, logic fl_);
      en = en_; dv = dv_; err = er_; ii = ii_; fl = fl_;
      for (int j = 0; j < 8; j++) din[32*j +: 32] = $urandom;
   endtask

   task automatic add(logic dv_, logic er_, logic fl_, logic [255:0] d_,
                      logic v_, logic id_, logic pt_, logic dn_, logic ee_,
                      int lv_, logic cd_, logic [191:0] ed_);
      vec_t r;
      r.en = 1'b1; r.dv = dv_; r.er = er_; r.ii = 1'b1; r.fl = fl_; r.din = d_;
      r.e_vld = v_; r.e_idle = id_; r.e_part = pt_; r.e_done = dn_; r.e_err = ee_;
      r.e_lvl = lv_; r.e_cd = cd_; r.e_data = ed_;
      tbl.push_back(r);
   endtask

   task automatic do_reset(int cycles);
      reset_n = 1'b0;
      en = 0; dv = 0; err = 0; ii = 0; fl = 0;
      repeat (cycles) tick();
      reset_n = 1'b1;
   endtask

   task automatic random_run(int cycles, int reset_at);
      for (int c = 0; c < cycles; c++) begin
         if (c == reset_at) do_reset(2);
         set_in(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) < 7),
                ($urandom_range(0, 29) == 0));
         tick();
      end
   endtask

   logic [255:0] w1, w2, w3, w4;
   logic [191:0] z;

   initial begin
      for (int j = 0; j < 8; j++) begin
         w1[32*j +: 32] = 32'h1000_0000 + 32'(j * 32'h0101) + 32'h01;
         w2[32*j +: 32] = 32'h2000_0000 + 32'(j * 32'h0101) + 32'h02;
         w3[32*j +: 32] = 32'h3000_0000 + 32'(j * 32'h0101) + 32'h03;
         w4[32*j +: 32] = 32'h4000_0000 + 32'(j * 32'h0101) + 32'h04;
      end
      z = '0;
      //    dv er fl din  vld idle part done err lvl chkdata data
      add(1, 0, 0, w1,   0, 1, 0, 0, 0,   0, 0, z);
      add(1, 1, 0, w2,   1, 1, 0, 0, 0, 256, 1, w1[191:0]);
      add(1, 0, 0, w3,   1, 1, 0, 0, 1, 320, 1, {w2[127:0], w1[255:192]});
      add(0, 0, 0, w1,   1, 1, 0, 0, 1, 384, 1, {w3[63:0], w2[255:128]});
      add(0, 0, 0, w1,   1, 1, 0, 0, 0, 192, 1, w3[255:64]);
      add(0, 0, 0, w1,   0, 1, 0, 0, 0,   0, 0, z);
      add(1, 0, 0, w4,   0, 1, 0, 0, 0,   0, 0, z);
      add(0, 0, 1, w1,   1, 1, 0, 0, 0, 256, 1, w4[191:0]);
      add(0, 0, 0, w1,   1, 0, 1, 0, 0,  64, 1, {128'b0, w4[255:192]});
      add(0, 0, 0, w1,   0, 1, 0, 1, 0,   0, 0, z);
      add(0, 0, 1, w1,   0, 1, 0, 0, 0,   0, 0, z);
      add(0, 0, 0, w1,   0, 1, 0, 1, 0,   0, 0, z);
      add(0, 0, 0, w1,   0, 1, 0, 0, 0,   0, 0, z);
      add(1, 0, 0, w1,   0, 1, 0, 0, 0,   0, 0, z);
      add(1, 0, 0, w2,   1, 1, 0, 0, 0, 256, 0, z);
      add(1, 0, 0, w3,   1, 1, 0, 0, 0, 320, 0, z);
      add(1, 0, 0, w4,   1, 1, 0, 0, 0, 384, 0, z);
      add(1, 0, 0, w1,   1, 0, 0, 0, 0, 448, 0, z);
      add(0, 0, 0, w1,   1, 1, 0, 0, 0, 256, 0, z);
      add(0, 0, 1, w1,   0, 1, 0, 0, 0,  64, 0, z);
      add(0, 0, 0, w1,   1, 0, 1, 0, 0,  64, 0, z);
      add(0, 0, 0, w1,   0, 1, 0, 1, 0,   0, 0, z);

      sel = 1'b0; iw = 256; ow = 192; bw = 448;
      reset_n = 1'b1;
      en = 0; dv = 0; err = 0; ii = 0; fl = 0; din = '0;
      #1;
      do_reset(3);

      foreach (tbl[k]) begin
         en = tbl[k].en; dv = tbl[k].dv; err = tbl[k].er;
         ii = tbl[k].ii; fl = tbl[k].fl; din = tbl[k].din;
         at_neg();
         chk($sformatf("t%0d_vld", k), {255'b0, d_vld}, {255'b0, tbl[k].e_vld});
         chk($sformatf("t%0d_idle", k), {255'b0, d_idle}, {255'b0, tbl[k].e_idle});
         chk($sformatf("t%0d_part", k), {255'b0, d_part}, {255'b0, tbl[k].e_part});
         chk($sformatf("t%0d_done", k), {255'b0, d_done}, {255'b0, tbl[k].e_done});
         chk($sformatf("t%0d_lvl", k), {224'b0, d_lvl}, 256'(tbl[k].e_lvl));
         if (tbl[k].e_vld)
            chk($sformatf("t%0d_err", k), {255'b0, d_err}, {255'b0, tbl[k].e_err});
         if (tbl[k].e_cd)
            chk($sformatf("t%0d_data", k), d_data, {64'b0, tbl[k].e_data});
         to_next();
      end

      // Downstream stall with a full buffer, then release and drain.
      repeat (4) begin set_in(1, 1, 0, 1, 0); tick(); end
      repeat (10) begin
         set_in(1, 1, 0, 0, 0);
         at_neg();
         chk("stall_lvl", {224'b0, d_lvl}, 256'd448);
         chk("stall_vld", {255'b0, d_vld}, '0);
         to_next();
      end
      repeat (4) begin set_in(1, 0, 0, 1, 0); tick(); end
      set_in(1, 0, 0, 1, 1); tick();
      repeat (3) begin set_in(1, 0, 0, 1, 0); tick(); end

      // Freeze mid-stream.
      repeat (2) begin set_in(1, 1, 0, 1, 0); tick(); end
      repeat (4) begin
         set_in(0, 1, 0, 1, 1);
         at_neg();
         chk("frz_lvl", {224'b0, d_lvl}, 256'd320);
         chk("frz_vld", {255'b0, d_vld}, '0);
         chk("frz_idle", {255'b0, d_idle}, '0);
         to_next();
      end
      repeat (3) begin set_in(1, 0, 0, 1, 0); tick(); end

      // Freeze mid-flush.
      set_in(1, 0, 0, 0, 1); tick();
      set_in(1, 1, 0, 0, 0); tick();
      repeat (3) begin
         set_in(0, 1, 0, 1, 0);
         at_neg();
         chk("ffrz_lvl", {224'b0, d_lvl}, 256'd128);
         chk("ffrz_vld", {255'b0, d_vld}, '0);
         chk("ffrz_done", {255'b0, d_done}, '0);
         to_next();
      end
      repeat (3) begin set_in(1, 0, 0, 1, 0); tick(); end

      random_run(300, -1);

      do_reset(2);
      sel = 1'b1; iw = 64; ow = 48; bw = 111;
      do_reset(2);
      random_run(600, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

endmodule
